// File: rtl/bram_arbiter_2p.sv
// Two-port arbiter in front of a single-port synchronous-read RAM, with lock support.
// Define BRAM_ARB_RR_EN for round-robin tie-breaking; default build uses fixed priority (port 0).
module bram_arbiter_2p #(
   parameter int unsigned ADDR_W = 23,
   parameter int unsigned DATA_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_valid,
   output logic              p0_ready,
   input  logic              p0_we,
   input  logic              p0_lock,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_valid,
   output logic              p1_ready,
   input  logic              p1_we,
   input  logic              p1_lock,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout
);

   typedef enum logic [1:0] {StFree, StOwn0, StOwn1} state_e;

   state_e state_q, state_d;
   logic   gnt0, gnt1;
   logic   acc, acc_port, acc_we, acc_lock;
   logic [ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0] acc_wdata;
   logic   rd_s1_q, rd_s1_port_q;

`ifdef BRAM_ARB_RR_EN
   // 0: port 0 wins the next tie, 1: port 1 wins.
   logic prio_q, prio_d;
`endif

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state_q)
         StFree: begin
`ifdef BRAM_ARB_RR_EN
            if (p0_valid && p1_valid) begin
               gnt0 = ~prio_q;
               gnt1 = prio_q;
            end else begin
               gnt0 = p0_valid;
               gnt1 = p1_valid;
            end
`else
            gnt0 = p0_valid;
            gnt1 = p1_valid & ~p0_valid;
`endif
         end
         StOwn0: gnt0 = 1'b1;
         StOwn1: gnt1 = 1'b1;
         default: begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      endcase
   end

   assign p0_ready = gnt0 & p0_valid & ~reset;
   assign p1_ready = gnt1 & p1_valid & ~reset;

   assign acc       = p0_ready | p1_ready;
   assign acc_port  = p1_ready;
   assign acc_we    = acc_port ? p1_we    : p0_we;
   assign acc_lock  = acc_port ? p1_lock  : p0_lock;
   assign acc_addr  = acc_port ? p1_addr  : p0_addr;
   assign acc_wdata = acc_port ? p1_wdata : p0_wdata;

   always_comb begin
      state_d = state_q;
      if (acc) begin
         if (acc_lock) state_d = acc_port ? StOwn1 : StOwn0;
         else          state_d = StFree;
      end
   end

`ifdef BRAM_ARB_RR_EN
   // Every beat of a burst favours the other port, so a burst counts as one grant.
   always_comb begin
      prio_d = prio_q;
      if (acc) prio_d = ~acc_port;
   end

   always_ff @(posedge clk) begin
      if (reset) prio_q <= 1'b0;
      else       prio_q <= prio_d;
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StFree;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_din      <= '0;
         rd_s1_q      <= 1'b0;
         rd_s1_port_q <= 1'b0;
         p0_rvalid    <= 1'b0;
         p1_rvalid    <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_we  <= acc & acc_we;
         if (acc) begin
            mem_addr <= acc_addr;
            mem_din  <= acc_wdata;
         end
         rd_s1_q      <= acc & ~acc_we;
         rd_s1_port_q <= acc_port;
         p0_rvalid    <= rd_s1_q & ~rd_s1_port_q;
         p1_rvalid    <= rd_s1_q & rd_s1_port_q;
      end
   end

   // RAM output is valid in the cycle rvalid is high; gate it so idle data reads as zero.
   assign p0_rdata = p0_rvalid ? mem_dout : '0;
   assign p1_rdata = p1_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_bram_arbiter_2p.sv
// Self-checking bench for bram_arbiter_2p with a behavioural RAM and a read-response scoreboard.
// Expectations follow BRAM_ARB_RR_EN when it is defined for the build.
module tb_bram_arbiter_2p;
   localparam int unsigned AW = 23;
   localparam int unsigned DW = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic p0_valid = 1'b0, p0_we = 1'b0, p0_lock = 1'b0, p0_ready, p0_rvalid;
   logic p1_valid = 1'b0, p1_we = 1'b0, p1_lock = 1'b0, p1_ready, p1_rvalid;
   logic [AW-1:0] p0_addr = '0, p1_addr = '0, mem_addr;
   logic [DW-1:0] p0_wdata = '0, p1_wdata = '0, p0_rdata, p1_rdata, mem_din, mem_dout;
   logic mem_we;

   always #5 clk = ~clk;

   bram_arbiter_2p #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_lock(p0_lock),
      .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_lock(p1_lock),
      .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a[DW-1:0] ^ 16'h5A3C;
   endfunction

   // Behavioural read-first synchronous RAM; unwritten words hold dflt(addr).
   logic [DW-1:0] ram [logic [AW-1:0]];
   always @(posedge clk) begin
      mem_dout <= ram.exists(mem_addr) ? ram[mem_addr] : dflt(mem_addr);
      if (mem_we) ram[mem_addr] = mem_din;
   end

   typedef struct {
      logic          port;
      logic [DW-1:0] data;
      int            due;
   } exp_t;

   exp_t          sb[$];
   exp_t          mon_e;
   logic [DW-1:0] sh [logic [AW-1:0]];

   // Response monitor: every rvalid must match the oldest expected read, in its due cycle.
   always @(negedge clk) begin
      if (p0_rvalid || p1_rvalid) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL rsp_unexpected: cycle %0d p0_rvalid=%0b p1_rvalid=%0b, required none",
                     cyc, p0_rvalid, p1_rvalid);
         end else begin
            mon_e = sb.pop_front();
            if ((p0_rvalid && p1_rvalid) || (p1_rvalid !== mon_e.port) ||
                ((mon_e.port ? p1_rdata : p0_rdata) !== mon_e.data) || (cyc != mon_e.due)) begin
               n_bad++;
               $display("FAIL rsp_match: cycle %0d rv0=%0b rv1=%0b d0=%h d1=%h, required port %0d data %h cycle %0d",
                        cyc, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, mon_e.port, mon_e.data,
                        mon_e.due);
            end
         end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
         n_cmp++;
         n_bad++;
         mon_e = sb.pop_front();
         $display("FAIL rsp_missing: cycle %0d got no rvalid, required port %0d data %h",
                  cyc, mon_e.port, mon_e.data);
      end
   end

   task automatic record(input logic port, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
      exp_t e;
      if (we) begin
         sh[a] = d;
      end else begin
         e.port = port;
         e.data = sh.exists(a) ? sh[a] : dflt(a);
         e.due  = cyc + 2;
         sb.push_back(e);
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      if (p0_ready && p0_valid) record(1'b0, p0_we, p0_addr, p0_wdata);
      if (p1_ready && p1_valid) record(1'b1, p1_we, p1_addr, p1_wdata);
   endtask

   task automatic to_next();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic port, input logic v, input logic we, input logic lk,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      if (port) begin
         p1_valid = v; p1_we = we; p1_lock = lk; p1_addr = a; p1_wdata = d;
      end else begin
         p0_valid = v; p0_we = we; p0_lock = lk; p0_addr = a; p0_wdata = d;
      end
   endtask

   task automatic idle();
      p0_valid = 1'b0;
      p1_valid = 1'b0;
   endtask

   task automatic apply_reset();
      idle();
      reset = 1'b1;
      sb.delete();
      to_next();
      to_next();
      reset = 1'b0;
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 4; i++) begin
         to_neg();
         to_next();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sb.delete();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 23'h000020, 16'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 23'h000030, 16'h0);
      to_next();
      to_neg();
      n_cmp++;
      if ({p0_ready, p1_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL reset_ready: got %b, required 00", {p0_ready, p1_ready});
      end
      n_cmp++;
      if ({mem_we, mem_addr, mem_din} !== '0) begin
         n_bad++;
         $display("FAIL reset_mem: got we=%b addr=%h din=%h, required all zero",
                  mem_we, mem_addr, mem_din);
      end
      n_cmp++;
      if ({p0_rvalid, p1_rvalid, p0_rdata, p1_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_rsp: got rv=%b%b d0=%h d1=%h, required zero",
                  p0_rvalid, p1_rvalid, p0_rdata, p1_rdata);
      end
      to_next();
      reset = 1'b0;
      to_neg();
      n_cmp++;
      if ({p0_ready, p1_ready} !== 2'b10) begin
         n_bad++;
         $display("FAIL first_grant: got %b, required 10", {p0_ready, p1_ready});
      end
      to_next();
      drain();
   endtask

   task automatic test_single_read();
      apply_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 23'h000010, 16'hBEEF);
      to_neg();
      to_next();
      idle();
      to_neg();
      to_next();
      to_neg();
      to_next();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 23'h000010, 16'h0);
      to_neg();
      n_cmp++;
      if (p0_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL single_ready: got %b, required 1", p0_ready);
      end
      to_next();
      idle();
      to_neg();
      n_cmp++;
      if (mem_addr !== 23'h000010 || mem_we !== 1'b0) begin
         n_bad++;
         $display("FAIL single_mem: got addr=%h we=%b, required 000010 0", mem_addr, mem_we);
      end
      to_next();
      to_neg();
      n_cmp++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== 16'hBEEF || p1_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL single_rsp: got rv0=%b d0=%h rv1=%b, required 1 BEEF 0",
                  p0_rvalid, p0_rdata, p1_rvalid);
      end
      to_next();
      drain();
   endtask

   task automatic test_write_read();
      apply_reset();
      drive(1'b1, 1'b1, 1'b1, 1'b0, 23'h7FFFFF, 16'h1234);
      to_neg();
      n_cmp++;
      if (p1_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL wr_ready: got %b, required 1", p1_ready);
      end
      to_next();
      drive(1'b1, 1'b1, 1'b0, 1'b0, 23'h7FFFFF, 16'h0);
      to_neg();
      n_cmp++;
      if (p1_ready !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 23'h7FFFFF ||
          mem_din !== 16'h1234) begin
         n_bad++;
         $display("FAIL wr_mem: got rdy=%b we=%b addr=%h din=%h, required 1 1 7fffff 1234",
                  p1_ready, mem_we, mem_addr, mem_din);
      end
      to_next();
      idle();
      to_neg();
      n_cmp++;
      if (mem_we !== 1'b0 || mem_addr !== 23'h7FFFFF) begin
         n_bad++;
         $display("FAIL rd_mem: got we=%b addr=%h, required 0 7fffff", mem_we, mem_addr);
      end
      to_next();
      to_neg();
      n_cmp++;
      if (p1_rvalid !== 1'b1 || p1_rdata !== 16'h1234) begin
         n_bad++;
         $display("FAIL raw_rsp: got rv1=%b d1=%h, required 1 1234", p1_rvalid, p1_rdata);
      end
      to_next();
      drain();
   endtask

   task automatic test_contention();
      logic exp0;
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b0, 1'b1, 1'b0, 1'b0, 23'h000100 + 23'(i), 16'h0);
         drive(1'b1, 1'b1, 1'b0, 1'b0, 23'h000200 + 23'(i), 16'h0);
`ifdef BRAM_ARB_RR_EN
         exp0 = (i % 2) == 0;
`else
         exp0 = 1'b1;
`endif
         to_neg();
         n_cmp++;
         if (p0_ready !== exp0 || p1_ready !== ~exp0) begin
            n_bad++;
            $display("FAIL contention[%0d]: got %b%b, required %b%b", i, p0_ready, p1_ready,
                     exp0, ~exp0);
         end
         to_next();
      end
      drain();
   endtask

   task automatic test_lock_burst();
      logic v0 [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      logic v1 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic l1 [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic e0 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, v0[i], 1'b0, 1'b0, 23'h000300, 16'h0);
         drive(1'b1, v1[i], 1'b0, l1[i], 23'h000400 + 23'(i), 16'h0);
         to_neg();
         n_cmp++;
         if (p0_ready !== e0[i] || p1_ready !== v1[i]) begin
            n_bad++;
            $display("FAIL lock[%0d]: got %b%b, required %b%b", i, p0_ready, p1_ready,
                     e0[i], v1[i]);
         end
         to_next();
      end
      drain();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b1, 23'h000500, 16'h0);
      to_neg();
      n_cmp++;
      if (p0_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL mid_accept: got %b, required 1", p0_ready);
      end
      to_next();
      reset = 1'b1;
      sb.delete();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 23'h0, 16'h0);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 23'h000600, 16'h0);
      to_neg();
      to_next();
      reset = 1'b0;
      to_neg();
      n_cmp++;
      if (p1_ready !== 1'b1 || p0_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_release: got rdy1=%b rv0=%b, required 1 0", p1_ready, p0_rvalid);
      end
      to_next();
      idle();
      to_neg();
      n_cmp++;
      if (p0_rvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_norsp: got rv0=%b, required 0", p0_rvalid);
      end
      to_next();
      drain();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_write_read();
      test_contention();
      test_lock_burst();
      test_reset_mid();
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d outstanding, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/bram_arbiter_2p.md
BRAM_ARBITER_2P -- requirements
Module: bram_arbiter_2p

Interface
REQ-001 Parameter ADDR_W, default 23: memory word-address width.
REQ-002 Parameter DATA_W, default 16: memory data width.
REQ-003 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pN_valid  input  1  (N=0,1) requester N presents a command.
REQ-007 pN_ready  output  1  command from requester N accepted this cycle.
REQ-008 pN_we  input  1  1 = write, 0 = read.
REQ-009 pN_lock  input  1  keep grant for following beats.
REQ-010 pN_addr  input  ADDR_W  word address.
REQ-011 pN_wdata  input  DATA_W  write data.
REQ-012 pN_rvalid  output  1  read response for requester N.
REQ-013 pN_rdata  output  DATA_W  read data, meaningful only while pN_rvalid=1.
REQ-014 mem_we, mem_addr, mem_din  output  1/ADDR_W/DATA_W  registered command to single-port synchronous-read RAM.
REQ-015 mem_dout  input  DATA_W  RAM read data, valid one cycle after mem_addr is presented.

Function
REQ-016 States SHALL be: FREE, OWN0, OWN1.
REQ-017 In FREE: grant one valid requester per cycle per the arbitration policy (REQ-030/031); pN_ready = grant & pN_valid; at most one pN_ready high per cycle.
REQ-018 In OWNx: only port x eligible; the other port's ready SHALL be 0 even when port x is idle.
REQ-019 Accepted beat with pN_lock=1 -> next state OWNN; with pN_lock=0 -> FREE.
REQ-020 Accepted command at edge N SHALL appear on mem_we/mem_addr/mem_din during cycle N+1; with no acceptance, mem_we SHALL be 0 (mem_addr/mem_din hold their previous value).
REQ-021 Accepted read at edge N SHALL produce pN_rvalid=1 for exactly one cycle (cycle N+2), with pN_rdata = mem_dout.
REQ-022 Writes SHALL produce no response.
REQ-023 Throughput: one accepted command per cycle sustained; no back-pressure beyond arbitration.
REQ-024 Responses SHALL return in acceptance order; a read-after-write to the same address, accepted in consecutive cycles, SHALL return the new data.
REQ-025 Address SHALL pass unmodified, full ADDR_W bits; no wrap or truncation inside the block.
REQ-026 Simultaneous pN_valid on both ports in FREE: exactly one grant; the loser holds its command and its ready stays 0.

Reset
REQ-027 On reset: state FREE, mem_we=0, mem_addr=0, mem_din=0, p0/p1_ready=0 during the reset cycle, p0/p1_rvalid=0, p0/p1_rdata=0, RR pointer favours port 0.
REQ-028 Reset mid-operation SHALL discard in-flight reads (no rvalid after reset) and release any lock.
REQ-029 The first grant SHALL be possible in the first cycle with reset=0.

Configuration
REQ-030 Macro BRAM_ARB_RR_EN defined: round-robin in FREE; the port not granted most recently wins a tie; a locked burst counts as one grant for the owner.
REQ-031 BRAM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties in FREE; lock behaviour unchanged.

Verification
REQ-032 Single read: p0 read addr 0x000010, RAM holds 0xBEEF -> p0_ready at cycle 0, mem_addr=0x000010 at cycle 1, p0_rvalid=1 with p0_rdata=0xBEEF at cycle 2, p1_rvalid stays 0.
REQ-033 Write then read: p1 writes 0x1234 to 0x7FFFFF, then reads 0x7FFFFF in the next cycle -> mem_we=1 for one cycle, then p1_rdata=0x1234 two cycles after read acceptance.
REQ-034 Contention: both ports valid every cycle for 8 cycles -> RR build: grants alternate 0,1,0,1,...; fixed build: 8 grants to p0, p1_ready=0 throughout.
REQ-035 Lock burst: p1 issues 4 beats with lock=1,1,1,0 while p0 valid -> p0_ready=0 until the cycle after p1's lock=0 beat, then p0 granted.
REQ-036 Reset mid-burst: reset asserted one cycle after a p0 read is accepted -> no p0_rvalid; state FREE; p1 granted in the first cycle after reset deasserts.
